// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Multicycle RV32I(+M) control unit. Each instruction is walked through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Memory accesses stall on
//   mem_ready and can time out. RV32M ops hand off to an iterative mul/div
//   unit. Illegal instructions and memory timeouts park the FSM in TRAP
//   until reset.
//
// Parameters
//   MULDIV_EN   : 1 = sequence RV32M through the mul/div unit, 0 = illegal
//   MEM_TIMEOUT : stall cycles tolerated in FETCH/MEM before trapping (0 = none)
//   CNT_W       : wait counter width, 2**CNT_W > MEM_TIMEOUT
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   instr/funct3/funct7 : opcode and function fields from the IR
//   mem_ready         : memory finishes the current access this cycle
//   muldiv_done       : mul/div result valid (pulse)
//   AluControl, AluSrc, Branch, regSel, memtoReg : datapath selects
//   regWrite, memRead, memWrite, irWrite, pcWrite : datapath strobes
//   muldiv_start      : one-cycle start pulse to the mul/div unit
//   trap, trapCause   : sticky halt flag and its cause
//   state             : current FSM state (0 FETCH .. 6 TRAP)
// ---------------------------------------------------------------------------
module mc_controller #(
  parameter int MULDIV_EN   = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] instr,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic [3:0] AluControl,
  output logic [1:0] regSel,
  output logic       AluSrc,
  output logic       memtoReg,
  output logic [2:0] Branch,
  output logic       regWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       muldiv_start,
  output logic       trap,
  output logic [1:0] trapCause,
  output logic [2:0] state
);

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operations
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [1:0] RSEL_PC4  = 2'b01;
  localparam logic [1:0] RSEL_IMM  = 2'b10;
  localparam logic [1:0] RSEL_MD   = 2'b11;

  localparam logic [2:0] BR_JUMP   = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             md_first_q, md_first_d;

  // ALU operation for the current IR. alt is funct7[5] (SUB/SRA select).
  function automatic logic [3:0] alu_sel(input logic [6:0] op,
                                         input logic [2:0] f3,
                                         input logic       alt);
    logic [3:0] r;
    r = ALU_ADD;
    if (op == OP_OP || op == OP_IMM) begin
      case (f3)
        3'b000:  r = (op == OP_OP && alt) ? ALU_SUB : ALU_ADD;
        3'b001:  r = ALU_SLL;
        3'b010:  r = ALU_SLT;
        3'b011:  r = ALU_SLTU;
        3'b100:  r = ALU_XOR;
        3'b101:  r = alt ? ALU_SRA : ALU_SRL;
        3'b110:  r = ALU_OR;
        default: r = ALU_AND;
      endcase
    end else if (op == OP_BRANCH) begin
      // The datapath derives the branch decision from the ALU flags.
      case (f3)
        3'b000, 3'b001: r = ALU_SUB;
        3'b100, 3'b101: r = ALU_SLT;
        default:        r = ALU_SLTU;
      endcase
    end else if (op == OP_LUI) begin
      r = ALU_PASSB;
    end
    return r;
  endfunction

  // Branch condition code from funct3 (only called for legal branches).
  function automatic logic [2:0] br_code(input logic [2:0] f3);
    logic [2:0] r;
    case (f3)
      3'b000:  r = 3'b001;
      3'b001:  r = 3'b010;
      3'b100:  r = 3'b011;
      3'b101:  r = 3'b100;
      3'b110:  r = 3'b101;
      default: r = 3'b110;
    endcase
    return r;
  endfunction

  // Instruction class decode
  logic is_op, is_imm, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_md, legal;

  always_comb begin
    is_op     = (instr == OP_OP);
    is_imm    = (instr == OP_IMM);
    is_load   = (instr == OP_LOAD);
    is_store  = (instr == OP_STORE);
    is_branch = (instr == OP_BRANCH);
    is_jal    = (instr == OP_JAL);
    is_jalr   = (instr == OP_JALR);
    is_lui    = (instr == OP_LUI);
    is_auipc  = (instr == OP_AUIPC);
    is_md     = is_op && (funct7 == F7_MULDIV) && (MULDIV_EN != 0);

    legal = 1'b0;
    if (is_op) begin
      legal = (funct7 == F7_BASE) || is_md ||
              ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
    end else if (is_imm) begin
      if (funct3 == 3'b001)      legal = (funct7 == F7_BASE);
      else if (funct3 == 3'b101) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      else                       legal = 1'b1;
    end else if (is_load) begin
      legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end else if (is_store) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else if (is_branch) begin
      legal = (funct3 != 3'b010) && (funct3 != 3'b011);
    end else if (is_jalr) begin
      legal = (funct3 == 3'b000);
    end else if (is_jal || is_lui || is_auipc) begin
      legal = 1'b1;
    end
  end

  // Stall/timeout: mem_ready on the expiry cycle still completes normally,
  // so expiry is only checked on the not-ready path below.
  logic waiting, timeout_hit;

  always_comb begin
    waiting     = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TIMEOUT_C);
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    md_first_d = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (is_md) begin
          state_d    = S_MULDIV;
          md_first_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch)               state_d = S_FETCH;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_MULDIV: if (muldiv_done) state_d = S_WB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && (MEM_TIMEOUT != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
      cause_q    <= CAUSE_NONE;
      md_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      md_first_q <= md_first_d;
    end
  end

  // Outputs: decoded from state and IR; reset forces everything low at once
  // so an aborted access drops its strobe in the reset cycle.
  always_comb begin
    AluControl   = 4'b0000;
    regSel       = 2'b00;
    AluSrc       = 1'b0;
    memtoReg     = 1'b0;
    Branch       = 3'b000;
    regWrite     = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    muldiv_start = 1'b0;
    trap         = 1'b0;
    trapCause    = CAUSE_NONE;
    state        = 3'd0;

    if (!reset) begin
      state     = state_q;
      trapCause = cause_q;
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          irWrite = mem_ready;
          pcWrite = mem_ready;
        end
        S_EXEC: begin
          AluControl = alu_sel(instr, funct3, funct7[5]);
          AluSrc     = !(is_op || is_branch);
          if (is_branch) begin
            Branch  = br_code(funct3);
            pcWrite = 1'b1;
          end
        end
        S_MEM: begin
          // Hold the address computation stable for the whole access.
          AluControl = ALU_ADD;
          AluSrc     = 1'b1;
          memRead    = is_load;
          memWrite   = is_store;
        end
        S_WB: begin
          regWrite = 1'b1;
          if (is_md) begin
            regSel = RSEL_MD;
          end else begin
            AluControl = alu_sel(instr, funct3, funct7[5]);
            AluSrc     = !is_op;
            memtoReg   = is_load;
            if (is_jal || is_jalr) begin
              regSel  = RSEL_PC4;
              Branch  = BR_JUMP;
              pcWrite = 1'b1;
            end else if (is_lui) begin
              regSel = RSEL_IMM;
            end
          end
        end
        S_MULDIV: muldiv_start = md_first_q;
        S_TRAP:   trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] instr;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       muldiv_done;

  logic [3:0] a_alu, b_alu;
  logic [1:0] a_rsel, b_rsel;
  logic       a_asrc, b_asrc, a_m2r, b_m2r;
  logic [2:0] a_br, b_br;
  logic       a_rw, a_mr, a_mw, a_irw, a_pcw, a_mds, a_trp;
  logic       b_rw, b_mr, b_mw, b_irw, b_pcw, b_mds, b_trp;
  logic [1:0] a_cause, b_cause;
  logic [2:0] a_st, b_st;

  // Main instance: mul/div enabled, short timeout.
  mc_controller #(.MULDIV_EN(1), .MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .instr(instr), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .AluControl(a_alu), .regSel(a_rsel), .AluSrc(a_asrc), .memtoReg(a_m2r),
    .Branch(a_br), .regWrite(a_rw), .memRead(a_mr), .memWrite(a_mw),
    .irWrite(a_irw), .pcWrite(a_pcw), .muldiv_start(a_mds), .trap(a_trp),
    .trapCause(a_cause), .state(a_st)
  );

  // Second instance: RV32M disabled, no timeout.
  mc_controller #(.MULDIV_EN(0), .MEM_TIMEOUT(0), .CNT_W(5)) dut_nomd (
    .clk(clk), .reset(reset), .instr(instr), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .AluControl(b_alu), .regSel(b_rsel), .AluSrc(b_asrc), .memtoReg(b_m2r),
    .Branch(b_br), .regWrite(b_rw), .memRead(b_mr), .memWrite(b_mw),
    .irWrite(b_irw), .pcWrite(b_pcw), .muldiv_start(b_mds), .trap(b_trp),
    .trapCause(b_cause), .state(b_st)
  );

  // {state, AluControl, regSel, AluSrc, memtoReg, Branch,
  //  regWrite, memRead, memWrite, irWrite, pcWrite, muldiv_start, trap, trapCause}
  logic [22:0] got_a, got_b;
  assign got_a = {a_st, a_alu, a_rsel, a_asrc, a_m2r, a_br,
                  a_rw, a_mr, a_mw, a_irw, a_pcw, a_mds, a_trp, a_cause};
  assign got_b = {b_st, b_alu, b_rsel, b_asrc, b_m2r, b_br,
                  b_rw, b_mr, b_mw, b_irw, b_pcw, b_mds, b_trp, b_cause};

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;
  localparam logic [6:0] F7_MD  = 7'b0000001;

  // Strobe groups {rw, mr, mw, irw, pcw, mds, trp}
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] FR = 7'b0101100;  // fetch, memory ready
  localparam logic [6:0] FW = 7'b0100000;  // fetch, waiting
  localparam logic [6:0] RW = 7'b1000000;
  localparam logic [6:0] PC = 7'b0000100;
  localparam logic [6:0] MR = 7'b0100000;
  localparam logic [6:0] MW = 7'b0010000;
  localparam logic [6:0] MS = 7'b0000010;
  localparam logic [6:0] TR = 7'b0000001;

  typedef struct {
    string       nm;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rdy;
    logic        dn;
    logic [22:0] exp;
  } vec_t;

  vec_t vq[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;
  int n_vec  = 0;
  int n_fail = 0;

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cur_op = op;
    cur_f3 = f3;
    cur_f7 = f7;
  endtask

  task automatic add(input string nm, input logic r, input logic rdy, input logic dn,
                     input logic [2:0] st, input logic [3:0] alu, input logic [1:0] rsel,
                     input logic asrc, input logic m2r, input logic [2:0] br,
                     input logic [6:0] strb, input logic [1:0] cause);
    vec_t v;
    v.nm  = nm;
    v.rst = r;
    v.op  = cur_op;
    v.f3  = cur_f3;
    v.f7  = cur_f7;
    v.rdy = rdy;
    v.dn  = dn;
    v.exp = {st, alu, rsel, asrc, m2r, br, strb, cause};
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [22:0] got, input logic [22:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h, expected %06h", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr = OP_R; funct3 = 3'b000; funct7 = 7'b0;
    mem_ready = 1'b0; muldiv_done = 1'b0;

    set_ir(OP_R, 3'b000, 7'b0);
    add("reset0", 1, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("reset1", 1, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("add_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("add_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("add_exec",  0, 1, 0, 2, 4'h2, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("add_wb",    0, 1, 0, 4, 4'h2, 2'b00, 0, 0, 3'b000, RW, 2'b00);

    set_ir(OP_LD, 3'b010, 7'b0);
    add("lw_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("lw_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("lw_exec",  0, 1, 0, 2, 4'h2, 2'b00, 1, 0, 3'b000, NO, 2'b00);
    for (int k = 0; k < 3; k++)
      add("lw_mem_wait", 0, 0, 0, 3, 4'h2, 2'b00, 1, 0, 3'b000, MR, 2'b00);
    add("lw_mem_done", 0, 1, 0, 3, 4'h2, 2'b00, 1, 0, 3'b000, MR, 2'b00);
    add("lw_wb",       0, 1, 0, 4, 4'h2, 2'b00, 1, 1, 3'b000, RW, 2'b00);

    set_ir(OP_BR, 3'b001, 7'b0);
    add("bne_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("bne_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("bne_exec",  0, 1, 0, 2, 4'h6, 2'b00, 0, 0, 3'b010, PC, 2'b00);

    set_ir(OP_JAL, 3'b000, 7'b0);
    add("jal_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("jal_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("jal_exec",  0, 1, 0, 2, 4'h2, 2'b00, 1, 0, 3'b000, NO, 2'b00);
    add("jal_wb",    0, 1, 0, 4, 4'h2, 2'b01, 1, 0, 3'b111, RW | PC, 2'b00);

    set_ir(OP_R, 3'b000, F7_MD);
    add("mul_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("mul_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("mul_start", 0, 1, 0, 5, 4'h0, 2'b00, 0, 0, 3'b000, MS, 2'b00);
    for (int k = 0; k < 3; k++)
      add("mul_wait", 0, 1, 0, 5, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("mul_done",  0, 1, 1, 5, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("mul_wb",    0, 1, 0, 4, 4'h0, 2'b11, 0, 0, 3'b000, RW, 2'b00);
    add("mul2_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("mul2_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("mul2_start_done", 0, 1, 1, 5, 4'h0, 2'b00, 0, 0, 3'b000, MS, 2'b00);
    add("mul2_wb",    0, 1, 0, 4, 4'h0, 2'b11, 0, 0, 3'b000, RW, 2'b00);

    set_ir(OP_LUI, 3'b000, 7'b0);
    add("lui_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("lui_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("lui_exec",  0, 1, 0, 2, 4'hF, 2'b00, 1, 0, 3'b000, NO, 2'b00);
    add("lui_wb",    0, 1, 0, 4, 4'hF, 2'b10, 1, 0, 3'b000, RW, 2'b00);

    set_ir(OP_ST, 3'b010, 7'b0);
    add("sw_fetch",    0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("sw_dec",      0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("sw_exec",     0, 1, 0, 2, 4'h2, 2'b00, 1, 0, 3'b000, NO, 2'b00);
    add("sw_mem_wait", 0, 0, 0, 3, 4'h2, 2'b00, 1, 0, 3'b000, MW, 2'b00);
    add("sw_reset",    1, 0, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("sw_after_rst", 0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FW, 2'b00);
    add("sw2_fetch",   0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("sw2_dec",     0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("sw2_exec",    0, 1, 0, 2, 4'h2, 2'b00, 1, 0, 3'b000, NO, 2'b00);
    add("sw2_mem",     0, 1, 0, 3, 4'h2, 2'b00, 1, 0, 3'b000, MW, 2'b00);

    set_ir(OP_BAD, 3'b000, 7'b0);
    add("ill_fetch", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("ill_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("ill_trap",  0, 0, 0, 6, 4'h0, 2'b00, 0, 0, 3'b000, TR, 2'b01);
    add("ill_hold",  0, 1, 0, 6, 4'h0, 2'b00, 0, 0, 3'b000, TR, 2'b01);
    add("ill_reset", 1, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);

    set_ir(OP_R, 3'b000, 7'b0);
    for (int k = 0; k < 4; k++)
      add("to_late_wait", 0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FW, 2'b00);
    add("to_late_ready", 0, 1, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FR, 2'b00);
    add("to_late_dec",   0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("to_late_exec",  0, 1, 0, 2, 4'h2, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("to_late_wb",    0, 1, 0, 4, 4'h2, 2'b00, 0, 0, 3'b000, RW, 2'b00);
    for (int k = 0; k < 5; k++)
      add("to_wait", 0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FW, 2'b00);
    add("to_trap",     0, 0, 0, 6, 4'h0, 2'b00, 0, 0, 3'b000, TR, 2'b10);
    add("to_hold",     0, 1, 0, 6, 4'h0, 2'b00, 0, 0, 3'b000, TR, 2'b10);
    add("to_reset",    1, 0, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, NO, 2'b00);
    add("to_released", 0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 3'b000, FW, 2'b00);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset       = vq[i].rst;
      instr       = vq[i].op;
      funct3      = vq[i].f3;
      funct7      = vq[i].f7;
      mem_ready   = vq[i].rdy;
      muldiv_done = vq[i].dn;
      #1;
      check(vq[i].nm, got_a, vq[i].exp);
    end

    // Long fetch stall: the timed instance traps, the untimed one keeps waiting.
    @(negedge clk);
    reset = 1'b1; instr = OP_R; funct3 = 3'b000; funct7 = 7'b0;
    mem_ready = 1'b0; muldiv_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("stall_timed_trap",  got_a, {3'd6, 4'h0, 2'b00, 1'b0, 1'b0, 3'b000, TR, 2'b10});
    check("stall_untimed_wait", got_b, {3'd0, 4'h0, 2'b00, 1'b0, 1'b0, 3'b000, FW, 2'b00});

    // MUL on both instances: enabled one sequences it, disabled one traps.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; funct7 = F7_MD; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mul_en_start",  got_a, {3'd5, 4'h0, 2'b00, 1'b0, 1'b0, 3'b000, MS, 2'b00});
    check("mul_dis_trap",  got_b, {3'd6, 4'h0, 2'b00, 1'b0, 1'b0, 3'b000, TR, 2'b01});

    // Mul/div unit answers after a few cycles; bounded wait for writeback.
    begin
      int cyc;
      cyc = 0;
      while (a_st != 3'd4 && cyc < 10) begin
        muldiv_done = (cyc == 2);
        @(negedge clk);
        #1;
        cyc++;
      end
      muldiv_done = 1'b0;
      check("mul_en_wb", got_a, {3'd4, 4'h0, 2'b11, 1'b0, 1'b0, 3'b000, RW, 2'b00});
      check("mul_dis_held", got_b, {3'd6, 4'h0, 2'b00, 1'b0, 1'b0, 3'b000, TR, 2'b01});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle successor to the single-cycle RV32I control unit. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Stalls on a memory ready handshake and handles a parametrised wait timeout.
- Optionally drives an iterative RV32M mul/div unit, and raises a sticky trap on illegal or failed operations.
- Sits between the instruction register/datapath and the shared ALU, register file and memory port.

Parameters:
MULDIV_EN, 1, 1 = decode RV32M (R-type, funct7=0000001) and sequence the mul/div unit; 0 = treat RV32M as illegal
MEM_TIMEOUT, 16, max cycles waiting for mem_ready in FETCH/MEM before trapping; 0 = wait forever
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr  in  7  opcode field from IR
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
mem_ready  in  1  memory completes the current read/write this cycle
muldiv_done  in  1  mul/div result valid (single-cycle pulse)
AluControl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1111 pass-B
regSel  out  2  writeback source: 00 ALU/mem, 01 oldPC+4, 10 immediate, 11 mul/div result
AluSrc  out  1  ALU B operand: 0 = rs2, 1 = immediate
memtoReg  out  1  writeback data comes from memory
Branch  out  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 unconditional
regWrite, memRead, memWrite, irWrite, pcWrite  out  1 each  strobes
muldiv_start  out  1  one-cycle start pulse
trap  out  1  sticky halt indication
trapCause  out  2  00 none, 01 illegal instruction, 10 memory timeout, 11 reserved
state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 MULDIV, 6 TRAP

Behaviour:
- Reset, sync active-high: while reset=1, every output is 0 and the wait counter is cleared. The first cycle after release is in FETCH. Reset mid-instruction aborts it with no further strobes.
- Outputs are Moore-style: a function of state plus the IR fields, with no combinational path from mem_ready to the strobes except as noted below.
- FETCH:
  - memRead=1 every cycle.
  - On mem_ready=1: irWrite=1, pcWrite=1 (PC+4 path; the datapath keeps oldPC), then go to DECODE.
- DECODE: 1 cycle, no strobes.
  - Illegal opcode, or RV32M with MULDIV_EN=0 → TRAP, cause 01.
  - RV32M with MULDIV_EN=1 → MULDIV.
  - Otherwise → EXEC.
- EXEC: 1 cycle. AluControl/AluSrc/Branch are driven from opcode/funct.
  - Branch class: the datapath qualifies pcWrite with the comparison result. pcWrite=1 with Branch≠000, then → FETCH.
  - Load/store → MEM.
  - All other classes → WB.
- MEM:
  - Load: memRead=1; on mem_ready → WB.
  - Store: memWrite=1; on mem_ready → FETCH.
- WB: regWrite=1 for 1 cycle, then → FETCH.
  - Load: memtoReg=1.
  - JAL/JALR: regSel=01, Branch=111, pcWrite=1.
  - LUI: regSel=10.
  - AUIPC: ALU ADD.
  - Mul/div: regSel=11.
- MULDIV:
  - muldiv_start=1 on the first cycle only; then hold until muldiv_done=1 → WB.
  - muldiv_done during the start cycle is accepted.
- Latency with zero-wait memory: branch 3 cycles; ALU/jump/store 4; load 5; mul/div 4 plus the unit latency.
- Timeout:
  - The counter increments each FETCH/MEM cycle with mem_ready=0 and clears on state change.
  - When the counter equals MEM_TIMEOUT (≠0) with mem_ready=0 → TRAP, cause 10.
  - mem_ready in the same cycle as expiry wins: normal completion.
- TRAP: trap=1, trapCause held, all strobes 0. Exited only by reset.
- x0 writes are not suppressed here; the register file handles them.

Test Plan:
- ADD (0110011/000/0000000), mem_ready always 1 → states 0,1,2,4,0; AluControl=0010 in EXEC; regWrite only in WB; 4 cycles.
- LW with mem_ready low for 3 cycles in MEM → memRead held 4 cycles; WB with memtoReg=1; total 8 cycles; no trap.
- BNE → Branch=010 and pcWrite=1 in EXEC; back to FETCH after 3 cycles. JAL → WB with regSel=01, Branch=111.
- MUL (funct7=0000001), MULDIV_EN=1, done after 5 cycles → single muldiv_start pulse, WB regSel=11. With MULDIV_EN=0 → TRAP, cause 01.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH → TRAP after 5 FETCH cycles, cause 10, strobes 0. Repeat with mem_ready on the expiry cycle → DECODE.
- Assert reset in MEM mid-store → memWrite drops the same cycle; after release, state=FETCH and trap=0.
